snn_reward_unit: RTL and testbench

//  Downstream stage of the spiking network core. Collects the core's 8-bit

---
 rtl/snn_reward_if.sv | 28 ++
 rtl/snn_reward_unit.sv | 124 ++++++++++++
 tb/tb_snn_reward_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/snn_reward_if.sv
// Handshake and data bundle between the reward unit and its neighbours:
// the sample stream from the spiking core, the window control, and the
// reward result channel towards the learning logic.
interface snn_reward_if #(
    parameter int DATA_W = 8
);
    logic              ena;
    logic              start;
    logic [DATA_W-1:0] target;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              reward_valid;
    logic              reward_ready;
    logic [1:0]        reward;
    logic [DATA_W-1:0] mean_out;

    modport master (
        output ena, start, target, in_valid, in_data, reward_ready,
        input  in_ready, busy, reward_valid, reward, mean_out
    );

    modport slave (
        input  ena, start, target, in_valid, in_data, reward_ready,
        output in_ready, busy, reward_valid, reward, mean_out
    );
endinterface

// File: rtl/snn_reward_unit.sv
// Reward unit: averages a fixed window of network output samples, compares
// the mean with a latched target and reports a signed reward (+1/0/-1)
// through a valid/ready handshake.
module snn_reward_unit #(
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 4,
    parameter int TOL      = 8
) (
    input logic         clk,
    input logic         rst,
    snn_reward_if.slave bus
);
    // The accumulator carries WIN_LOG2 guard bits, so a full window of
    // maximum-value samples fits without wrapping.
    localparam int ACC_W = DATA_W + WIN_LOG2;
    localparam logic [DATA_W:0] TOL_1X = (DATA_W + 1)'(TOL);
    localparam logic [DATA_W:0] TOL_2X = (DATA_W + 1)'(2 * TOL);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EVAL,
        REPORT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ACC_W-1:0]    acc;
    logic [WIN_LOG2-1:0] cnt;
    logic [DATA_W-1:0]   target_q;
    logic [DATA_W-1:0]   mean_q;
    logic [1:0]          reward_q;

    logic                accept;
    logic                last_sample;
    logic [DATA_W-1:0]   mean_calc;
    logic [DATA_W:0]     diff_calc;
    logic [1:0]          reward_calc;

    // A sample is taken only while accumulating and enabled; anything
    // offered in other states is simply dropped.
    assign accept      = (state == ACCUM) && bus.ena && bus.in_valid;
    assign last_sample = accept && (cnt == {WIN_LOG2{1'b1}});
    assign mean_calc   = acc[ACC_W-1:WIN_LOG2];

    assign bus.in_ready     = (state == ACCUM) && bus.ena;
    assign bus.busy         = (state != IDLE);
    assign bus.reward_valid = (state == REPORT);
    assign bus.reward       = reward_q;
    assign bus.mean_out     = mean_q;

    // Absolute distance between mean and target, one bit wider than the
    // data so the subtraction never borrows, then graded against tolerance.
    always_comb begin
        diff_calc   = '0;
        reward_calc = 2'b11;
        if (mean_calc >= target_q) begin
            diff_calc = {1'b0, mean_calc} - {1'b0, target_q};
        end else begin
            diff_calc = {1'b0, target_q} - {1'b0, mean_calc};
        end
        if (diff_calc <= TOL_1X) begin
            reward_calc = 2'b01;
        end else if (diff_calc <= TOL_2X) begin
            reward_calc = 2'b00;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; ena only gates window start and sample acceptance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start && bus.ena) state_next = ACCUM;
            ACCUM:   if (last_sample) state_next = EVAL;
            EVAL:    state_next = REPORT;
            REPORT:  if (bus.reward_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window datapath: latch target at start, accumulate accepted samples,
    // and capture the graded result when leaving EVAL. Results stay put
    // until the next window is evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            target_q <= '0;
            mean_q   <= '0;
            reward_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.ena) begin
                        target_q <= bus.target;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + ACC_W'(bus.in_data);
                        cnt <= cnt + WIN_LOG2'(1);
                    end
                end
                EVAL: begin
                    mean_q   <= mean_calc;
                    reward_q <= reward_calc;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snn_reward_unit.sv
// Self-checking bench for snn_reward_unit: directed scenarios with literal
// expectations, followed by a long randomized run, all compared cycle by
// cycle against a window-level behavioural model.
module tb_snn_reward_unit;
    localparam int WIN = 16;
    localparam int TOL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    snn_reward_if #(.DATA_W(8)) bus ();

    snn_reward_unit #(.DATA_W(8), .WIN_LOG2(4), .TOL(TOL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Behavioural model: a window is just a running sum and count of
    // accepted samples; the result appears one cycle after the last one.
    bit         m_accum = 1'b0;
    bit         m_pending = 1'b0;
    bit         m_report = 1'b0;
    int         m_n = 0;
    int         m_sum = 0;
    int         m_target = 0;
    int         p_mean = 0;
    logic [1:0] p_reward = 2'b00;
    logic [1:0] m_reward = 2'b00;
    logic [7:0] m_mean = 8'h00;

    function automatic logic [1:0] grade(input int mean, input int tgt);
        int d;
        d = (mean > tgt) ? mean - tgt : tgt - mean;
        if (d <= TOL) return 2'b01;
        if (d <= 2 * TOL) return 2'b00;
        return 2'b11;
    endfunction

    // Model update on every active edge, reset acting immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_accum   <= 1'b0;
            m_pending <= 1'b0;
            m_report  <= 1'b0;
            m_n       <= 0;
            m_sum     <= 0;
            m_target  <= 0;
            m_reward  <= 2'b00;
            m_mean    <= 8'h00;
        end else if (m_report) begin
            if (bus.reward_ready) m_report <= 1'b0;
        end else if (m_pending) begin
            m_pending <= 1'b0;
            m_report  <= 1'b1;
            m_mean    <= 8'(p_mean);
            m_reward  <= p_reward;
        end else if (m_accum) begin
            if (bus.in_valid && bus.ena) begin
                m_sum <= m_sum + int'(bus.in_data);
                m_n   <= m_n + 1;
                if (m_n == WIN - 1) begin
                    m_accum   <= 1'b0;
                    m_pending <= 1'b1;
                    p_mean    <= (m_sum + int'(bus.in_data)) / WIN;
                    p_reward  <= grade((m_sum + int'(bus.in_data)) / WIN, m_target);
                end
            end
        end else if (bus.start && bus.ena) begin
            m_accum  <= 1'b1;
            m_sum    <= 0;
            m_n      <= 0;
            m_target <= int'(bus.target);
        end
    end

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        check_output("in_ready", 16'(bus.in_ready), 16'(m_accum && bus.ena));
        check_output("busy", 16'(bus.busy), 16'(m_accum || m_pending || m_report));
        check_output("reward_valid", 16'(bus.reward_valid), 16'(m_report));
        check_output("reward", 16'(bus.reward), 16'(m_reward));
        check_output("mean_out", 16'(bus.mean_out), 16'(m_mean));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle worth of inputs, then advance past the next edge.
    task automatic apply_stimulus(input logic ena, input logic start, input logic [7:0] target,
                                  input logic in_valid, input logic [7:0] in_data,
                                  input logic ready);
        bus.ena          = ena;
        bus.start        = start;
        bus.target       = target;
        bus.in_valid     = in_valid;
        bus.in_data      = in_data;
        bus.reward_ready = ready;
        step();
    endtask

    // Start a window and feed WIN identical samples; ends in the first
    // REPORT cycle with reward_ready held low.
    task automatic run_window(input logic [7:0] target, input logic [7:0] value);
        apply_stimulus(1'b1, 1'b1, target, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < WIN; i++) apply_stimulus(1'b1, 1'b0, target, 1'b1, value, 1'b0);
        check_output("eval_not_valid", 16'(bus.reward_valid), 16'd0);
        apply_stimulus(1'b1, 1'b0, target, 1'b0, 8'h00, 1'b0);
        check_output("report_valid", 16'(bus.reward_valid), 16'd1);
    endtask

    task automatic release_report();
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check_output("idle_after_ack", 16'(bus.busy), 16'd0);
    endtask

    initial begin
        int offset;
        int v;
        bus.ena = 1'b0; bus.start = 1'b0; bus.target = 8'h00;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.reward_ready = 1'b0;
        step();
        step();
        check_output("reset_busy", 16'(bus.busy), 16'd0);
        check_output("reset_mean", 16'(bus.mean_out), 16'd0);
        rst = 1'b0;

        // Exact match, then 5 stall cycles in REPORT.
        run_window(8'h40, 8'h40);
        check_output("t1_reward", 16'(bus.reward), 16'h1);
        check_output("t1_mean", 16'(bus.mean_out), 16'h40);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            check_output("t4_hold_valid", 16'(bus.reward_valid), 16'd1);
            check_output("t4_hold_reward", 16'(bus.reward), 16'h1);
            check_output("t4_hold_mean", 16'(bus.mean_out), 16'h40);
        end
        release_report();

        // Tolerance boundaries.
        run_window(8'h40, 8'h48);
        check_output("diff_tol", 16'(bus.reward), 16'h1);
        release_report();
        run_window(8'h40, 8'h50);
        check_output("diff_2tol", 16'(bus.reward), 16'h0);
        check_output("t2_mean", 16'(bus.mean_out), 16'h50);
        release_report();
        run_window(8'h40, 8'h51);
        check_output("diff_2tol_p1", 16'(bus.reward), 16'h3);
        release_report();
        run_window(8'h00, 8'hFF);
        check_output("t3_mean", 16'(bus.mean_out), 16'hFF);
        check_output("t3_reward", 16'(bus.reward), 16'h3);

        // Start during the acknowledging cycle is ignored, seen next edge.
        apply_stimulus(1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 1'b1);
        check_output("start_on_ack", 16'(bus.busy), 16'd0);
        apply_stimulus(1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0);
        check_output("start_after_ack", 16'(bus.busy), 16'd1);

        // Window with ena low for 3 cycles; stray 0xFF samples must not count.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 8'h20, 1'b1, 8'h20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.ena = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hFF;
            #1;
            check_output("t5_in_ready", 16'(bus.in_ready), 16'd0);
            step();
        end
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 8'h20, 1'b1, 8'h20, 1'b0);
        check_output("t5_one_short", 16'(bus.busy && bus.in_ready), 16'd1);
        apply_stimulus(1'b1, 1'b0, 8'h20, 1'b1, 8'h20, 1'b0);
        apply_stimulus(1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
        check_output("t5_valid", 16'(bus.reward_valid), 16'd1);
        check_output("t5_mean", 16'(bus.mean_out), 16'h20);
        release_report();

        // Reset after 7 samples clears everything immediately.
        apply_stimulus(1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 1'b0, 8'h10, 1'b1, 8'h90, 1'b0);
        rst = 1'b1;
        #1;
        check_output("t6_busy", 16'(bus.busy), 16'd0);
        check_output("t6_mean", 16'(bus.mean_out), 16'd0);
        check_output("t6_reward", 16'(bus.reward), 16'd0);
        step();
        rst = 1'b0;
        run_window(8'h10, 8'h10);
        check_output("t6_clean_mean", 16'(bus.mean_out), 16'h10);
        check_output("t6_clean_reward", 16'(bus.reward), 16'h1);
        release_report();

        // Randomized traffic around the target, occasional resets.
        offset = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            bus.ena   = ($urandom_range(0, 9) != 0);
            bus.start = ($urandom_range(0, 5) == 0);
            if (bus.start) begin
                bus.target = 8'($urandom_range(0, 255));
                offset     = int'($urandom_range(0, 40)) - 20;
            end
            bus.in_valid = ($urandom_range(0, 9) < 7);
            v = int'(bus.target) + offset + int'($urandom_range(0, 2)) - 1;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            bus.in_data      = 8'(v);
            bus.reward_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
